// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 8;

  // Sequential PC advance applied after every fetched word.
  localparam int PC_STEP = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one word per PC value from a synchronous
// instruction memory, hands it to the decoder over valid/ready, and steers
// the PC by +1 or by a relative branch offset. Halts once the PC wraps.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_val,
  input  logic               pc_max_reached,
  output logic               pc_inc,
  output logic [ADDR_W-1:0]  pc_inc_val,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_off,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;

  // State and captured instruction registers; reset drops any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

  // Next-state and strobe decode; every strobe is driven only from its state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ipc_d       = ipc_q;
    pc_inc      = 1'b0;
    pc_inc_val  = '0;
    imem_rd_en  = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        // A set wrap flag means the previous word was the last one.
        if (pc_max_reached) begin
          state_d = S_HALT;
        end else begin
          imem_rd_en = 1'b1;
          imem_addr  = pc_val;
          addr_d     = pc_val;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // Memory data is valid now; advance the PC past this word.
        data_d     = imem_rdata;
        ipc_d      = addr_q;
        pc_inc     = 1'b1;
        pc_inc_val = ADDR_W'(PC_STEP);
        state_d    = S_OUT;
      end

      S_OUT: begin
        instr_valid = 1'b1;
        // A branch wins over ready: the word is dropped without handshake
        // and the PC (already past this word) is moved by the offset.
        if (branch_req) begin
          pc_inc     = 1'b1;
          pc_inc_val = branch_off;
          state_d    = S_FETCH;
        end else if (instr_ready) begin
          state_d = run ? S_FETCH : S_IDLE;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    instr_data = data_q;
    instr_pc   = ipc_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a PC model, a synchronous ROM,
// and an address-level reference of which word must be delivered next.
module tb_instr_fetch;

  localparam int AW = 5;
  localparam int IW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [AW-1:0] pc_val = '0;
  logic          pc_max_reached = 1'b0;
  logic          pc_inc;
  logic [AW-1:0] pc_inc_val;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          branch_req = 1'b0;
  logic [AW-1:0] branch_off = '0;
  logic          halted;

  logic [IW-1:0] rom [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cyc = 0;
  int vcyc = 0;
  int prev_vcyc = 0;
  int exp_addr = 0;

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .pc_val         (pc_val),
    .pc_max_reached (pc_max_reached),
    .pc_inc         (pc_inc),
    .pc_inc_val     (pc_inc_val),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .branch_req     (branch_req),
    .branch_off     (branch_off),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // PC: adds the increment modulo 2^AW and latches a sticky wrap flag.
  always @(posedge clk) begin
    logic [AW:0] sum;
    if (rst) begin
      pc_val         <= '0;
      pc_max_reached <= 1'b0;
    end else if (pc_inc) begin
      sum = {1'b0, pc_val} + {1'b0, pc_inc_val};
      pc_val <= sum[AW-1:0];
      if (sum[AW]) pc_max_reached <= 1'b1;
    end
  end

  // Synchronous-read instruction ROM.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= rom[imem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the always-true strobe rules.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check("inc_rd_exclusive", 32'(pc_inc & imem_rd_en), 0);
    if (!pc_inc) check("inc_val_idle", 32'(pc_inc_val), 0);
    else if (!instr_valid) check("inc_val_seq", 32'(pc_inc_val), 1);
    else check("inc_val_branch", 32'(pc_inc_val), 32'(branch_off));
    if (imem_rd_en) begin
      check("imem_addr", 32'(imem_addr), 32'(pc_val));
      rd_cyc = cyc;
    end
  endtask

  // Wait for instr_valid while scribbling on branch/ready, which must be ignored.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        branch_req  = 1'b0;
        branch_off  = '0;
        instr_ready = 1'b0;
        vcyc = cyc;
        return;
      end
      branch_req  = 1'($urandom % 2);
      branch_off  = AW'($urandom);
      instr_ready = 1'($urandom % 2);
      tick();
    end
    check("valid_timeout", 0, 1);
  endtask

  // Receive one word, optionally stall, then accept it or branch away.
  task automatic deliver(input bit br, input int off, input int stall);
    bit ok;
    wait_valid(ok);
    if (!ok) return;
    check("instr_pc", 32'(instr_pc), 32'(exp_addr));
    check("instr_data", 32'(instr_data), 32'(rom[exp_addr]));
    check("fetch_latency", 32'(vcyc - rd_cyc), 2);
    for (int s = 0; s < stall; s++) begin
      instr_ready = 1'b0;
      tick();
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_data", 32'(instr_data), 32'(rom[exp_addr]));
      check("stall_rd", 32'(imem_rd_en), 0);
      check("stall_inc", 32'(pc_inc), 0);
    end
    if (br) begin
      branch_req  = 1'b1;
      branch_off  = AW'(off);
      instr_ready = 1'($urandom % 2);
      #1;
      check("branch_inc", 32'(pc_inc), 1);
      check("branch_inc_val", 32'(pc_inc_val), 32'(off));
      tick();
      branch_req = 1'b0;
      exp_addr = exp_addr + 1 + off;
    end else begin
      instr_ready = 1'b1;
      #1;
      check("accept_no_inc", 32'(pc_inc), 0);
      tick();
      exp_addr = exp_addr + 1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'hA0 + 8'(i);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_data", 32'(instr_data), 0);
    check("rst_pc", 32'(instr_pc), 0);
    check("rst_rd", 32'(imem_rd_en), 0);
    check("rst_halted", 32'(halted), 0);

    // Sequential run, one word every three cycles
    rst = 1'b0;
    run = 1'b1;
    exp_addr = 0;
    deliver(0, 0, 0);
    prev_vcyc = vcyc;
    deliver(0, 0, 0);
    check("throughput_1", 32'(vcyc - prev_vcyc), 3);
    prev_vcyc = vcyc;
    deliver(0, 0, 0);
    check("throughput_2", 32'(vcyc - prev_vcyc), 3);

    // Backpressure at address 3, then branch at address 4 to 4+1+6=11
    deliver(0, 0, 5);
    deliver(1, 6, 0);
    check("branch_target_model", 32'(exp_addr), 11);
    deliver(0, 0, 0);

    // Randomised traffic until the word at the top address is delivered
    while (exp_addr < DEPTH) begin
      bit br;
      int off;
      br  = (($urandom % 3) == 0) && (exp_addr < DEPTH - 1);
      off = 0;
      if (br) off = int'($urandom_range(0, (DEPTH - 2 - exp_addr) < 4 ? (DEPTH - 2 - exp_addr) : 4));
      deliver(br, off, int'($urandom % 3));
    end

    // Wrap: no read is issued, then halted with ready and run still high
    instr_ready = 1'b1;
    check("wrap_no_rd", 32'(imem_rd_en), 0);
    tick();
    check("halted", 32'(halted), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_hold", 32'(halted), 1);
      check("halt_no_rd", 32'(imem_rd_en), 0);
      check("halt_no_valid", 32'(instr_valid), 0);
    end

    // Reset while a word is pending in S_OUT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr = 0;
    begin
      bit ok;
      wait_valid(ok);
      check("rst_restart_pc", 32'(instr_pc), 0);
    end
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(instr_valid), 0);
    check("rst_mid_data", 32'(instr_data), 0);
    check("rst_mid_pc", 32'(instr_pc), 0);
    check("rst_mid_inc", 32'(pc_inc), 0);
    check("rst_mid_halted", 32'(halted), 0);
    rst = 1'b0;
    exp_addr = 0;
    deliver(0, 0, 0);

    // run dropped while the read is outstanding: word completes, then idle
    check("fetch_issued", 32'(imem_rd_en), 1);
    tick();
    run = 1'b0;
    deliver(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_no_rd", 32'(imem_rd_en), 0);
      check("idle_no_valid", 32'(instr_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage sitting directly downstream of the program counter.
- Takes the PC value and reads one instruction word from a synchronous-read instruction memory.
- Presents the word to the decoder with a valid/ready handshake.
- Drives the PC's increment controls: +1 for sequential flow, or a relative offset for a taken branch. Stops cleanly once the PC reports wrap-around.

Parameters:
- ADDR_W, 5, PC/instruction-memory address width; must equal the PC counter width.
- INSTR_W, 8, instruction word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  fetch enable from control.
- pc_val  in  ADDR_W  current PC count.
- pc_max_reached  in  1  sticky PC wrap flag.
- pc_inc  out  1  one-cycle PC increment strobe.
- pc_inc_val  out  ADDR_W  increment amount applied with pc_inc.
- imem_rd_en  out  1  memory read strobe.
- imem_addr  out  ADDR_W  memory read address.
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en.
- instr_valid  out  1  instruction available to decoder.
- instr_ready  in  1  decoder accepts instruction.
- instr_data  out  INSTR_W  fetched instruction, held while instr_valid.
- instr_pc  out  ADDR_W  address instr_data was fetched from.
- branch_req  in  1  decoder requests a relative branch.
- branch_off  in  ADDR_W  branch offset, relative to the PC after the current instruction.
- halted  out  1  fetch stopped after PC wrap.

Behaviour:
- Reset: one clock, synchronous, active-high. State goes to S_IDLE. All outputs are 0, including instr_data and instr_pc.
- The PC module and this block are reset together at system level.
- FSM states: S_IDLE, S_FETCH, S_WAIT, S_OUT, S_HALT. All outputs are registered or decoded directly from state.
- S_IDLE: all strobes 0. If run=1, go to S_FETCH.
- S_FETCH:
  - If pc_max_reached=1: go to S_HALT; no read is issued.
  - Otherwise: imem_rd_en=1, imem_addr=pc_val; go to S_WAIT.
- S_WAIT:
  - Capture imem_rdata into instr_data and imem_addr into instr_pc.
  - Pulse pc_inc=1 with pc_inc_val=1; go to S_OUT.
- S_OUT:
  - instr_valid=1; instr_data and instr_pc are stable.
  - If branch_req=1: instruction is discarded with no handshake; pc_inc=1, pc_inc_val=branch_off; go to S_FETCH.
  - Else if instr_ready=1: handshake completes; go to S_FETCH if run=1, otherwise S_IDLE.
  - Else: stay in S_OUT.
- S_HALT: halted=1, all other strobes 0. Exit only through rst.
- Latency and throughput:
  - S_FETCH to instr_valid is 2 cycles.
  - With ready held high, sustained throughput is 1 instruction per 3 cycles.
- pc_inc and imem_rd_en are single-cycle pulses and are never asserted in the same cycle.
- pc_inc_val is 0 whenever pc_inc=0.
- Arithmetic: the branch target is (pc_val + branch_off) mod 2^ADDR_W, computed by the PC. This block performs no addition.
- PC boundary: the PC wraps to 0 and sets its flag when incremented from 2^ADDR_W-1.
  - The instruction fetched at address 2^ADDR_W-1 is still delivered.
  - The next S_FETCH sees pc_max_reached=1 and halts.
- branch_off=0 is legal: no PC change, re-fetch of pc_val. If the PC is at its maximum, it wraps and the block halts.
- branch_req outside S_OUT is ignored.
- instr_ready outside S_OUT is ignored.
- run deasserted mid-fetch: the current instruction completes its handshake or branch, then the block goes to S_IDLE.
- rst mid-operation: all outputs are 0 on the next cycle, any pending instruction is lost, and no pc_inc is issued.

Decomposition:
- Shared package holds the state enum (fetch_state_t), the ADDR_W/INSTR_W defaults, and the constant PC_STEP=1.
- Single module; no sub-module is needed.

Test Plan:
- Sequential run: ROM[i]=i+8'hA0, run=1, ready=1.
  - Required: instr_data A0,A1,A2 with instr_pc 0,1,2, one valid every 3 cycles.
  - Required: one pc_inc per fetch with pc_inc_val=1.
- Backpressure: ready=0 for 5 cycles at instr_pc=3.
  - Required: instr_valid stays 1 and instr_data stays A3 throughout.
  - Required: no imem_rd_en or pc_inc during the stall.
- Branch: at instr_pc=4 (PC=5), branch_req=1 with branch_off=6.
  - Required: pc_inc_val=6, and the next instr_pc is 11.
  - Required: the instruction at address 4 is never handshaked.
- Wrap/halt: run to instr_pc=31.
  - Required: A-word at address 31 is delivered, then halted=1.
  - Required: no further imem_rd_en, with ready still held at 1.
- Reset mid-S_OUT: rst asserted with instr_valid=1.
  - Required: next cycle all outputs are 0 and state is S_IDLE.
  - Required: after release with run=1, fetch restarts from pc_val=0.
- run deassert in S_WAIT: the pending instruction is delivered, then the block idles with no further reads.
